// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: memory-side end of the control unit's bus strobes.
// Runs one IDLE-T1-T2-T3 memory cycle per accepted request and returns
// read data to the CPU bus.
// Optional feature macro: BUS_WAIT_EN (T2 stretches on i_Mem_Ready, with a
// MAX_WAIT timeout that completes the cycle and returns OPEN_BUS on reads).
module cpu_bus_responder #(
   parameter int unsigned           ADDR_WIDTH = 16,
   parameter int unsigned           DATA_WIDTH = 8,
   parameter int unsigned           MAX_WAIT   = 15,
   parameter logic [DATA_WIDTH-1:0] OPEN_BUS   = 8'hFF
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset,
   input  logic                  i_Address_Out,
   input  logic                  i_Bus_In,
   input  logic                  i_Bus_Out,
   input  logic [ADDR_WIDTH-1:0] i_Address,
   input  logic [DATA_WIDTH-1:0] i_Data,
   output logic [DATA_WIDTH-1:0] o_Data,
   output logic                  o_Busy,
   output logic                  o_Done,
   output logic                  o_Conflict,
   output logic                  o_Timeout,
   output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
   output logic                  o_Mem_Rd,
   output logic                  o_Mem_Wr,
   output logic [DATA_WIDTH-1:0] o_Mem_WData,
   input  logic [DATA_WIDTH-1:0] i_Mem_RData,
   input  logic                  i_Mem_Ready
);

   typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
   typedef enum logic [1:0] {K_ADDR, K_READ, K_WRITE} kind_t;

   state_t                state;
   kind_t                 kind;
   logic [DATA_WIDTH-1:0] wdata_q;

`ifdef BUS_WAIT_EN
   localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   logic                  timeout_q;
   logic [WAIT_W-1:0]     wait_cnt;

   assign o_Timeout = timeout_q;
`else
   // Ready and the wait parameters have no effect when waits are disabled.
   logic unused_wait;
   assign unused_wait = i_Mem_Ready ^ (MAX_WAIT == 0) ^ (^OPEN_BUS);
   assign o_Timeout   = 1'b0;
`endif

   // Memory-cycle FSM with all outputs registered alongside the state.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state       <= IDLE;
         kind        <= K_ADDR;
         wdata_q     <= '0;
         o_Data      <= '0;
         o_Busy      <= 1'b0;
         o_Done      <= 1'b0;
         o_Conflict  <= 1'b0;
         o_Mem_Addr  <= '0;
         o_Mem_Rd    <= 1'b0;
         o_Mem_Wr    <= 1'b0;
         o_Mem_WData <= '0;
`ifdef BUS_WAIT_EN
         timeout_q   <= 1'b0;
         wait_cnt    <= '0;
`endif
      end else begin
         o_Conflict <= 1'b0;
`ifdef BUS_WAIT_EN
         timeout_q  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (i_Address_Out) begin
                  if (i_Bus_In && i_Bus_Out) begin
                     o_Conflict <= 1'b1;
                  end else begin
                     state      <= T1;
                     o_Busy     <= 1'b1;
                     o_Mem_Addr <= i_Address;
                     wdata_q    <= i_Data;
                     if (i_Bus_In)       kind <= K_READ;
                     else if (i_Bus_Out) kind <= K_WRITE;
                     else                kind <= K_ADDR;
`ifdef BUS_WAIT_EN
                     wait_cnt   <= '0;
`endif
                  end
               end
            end
            T1: begin
               state    <= T2;
               o_Mem_Rd <= (kind == K_READ);
               o_Mem_Wr <= (kind == K_WRITE);
               if (kind == K_WRITE) o_Mem_WData <= wdata_q;
            end
            T2: begin
`ifdef BUS_WAIT_EN
               if (i_Mem_Ready || (wait_cnt == WAIT_LAST)) begin
                  state    <= T3;
                  o_Mem_Rd <= 1'b0;
                  o_Mem_Wr <= 1'b0;
                  o_Done   <= 1'b1;
                  if (!i_Mem_Ready) begin
                     timeout_q <= 1'b1;
                     wait_cnt  <= wait_cnt + WAIT_W'(1);
                     if (kind == K_READ) o_Data <= OPEN_BUS;
                  end else if (kind == K_READ) begin
                     o_Data <= i_Mem_RData;
                  end
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
`else
               state    <= T3;
               o_Mem_Rd <= 1'b0;
               o_Mem_Wr <= 1'b0;
               o_Done   <= 1'b1;
               if (kind == K_READ) o_Data <= i_Mem_RData;
`endif
            end
            default: begin
               state  <= IDLE;
               o_Done <= 1'b0;
               o_Busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
